// File: rtl/microsequencer_pkg.sv
// -----------------------------------------------------------------------------
// microsequencer_pkg
// Shared definitions for the microprogram sequencer:
//   - seq_op encodings SEQ_INC .. SEQ_RSV
//   - width helpers for the condition-select field, the microinstruction word
//     and the stack level counter, all derived from the block parameters.
// Microinstruction layout, MSB to LSB: ctrl | next_addr | seq_op | cond_sel | inv
// -----------------------------------------------------------------------------
package microsequencer_pkg;

    localparam int SEQ_OP_W = 3;

    typedef enum logic [SEQ_OP_W-1:0] {
        SEQ_INC  = 3'd0,
        SEQ_JMP  = 3'd1,
        SEQ_DEC  = 3'd2,
        SEQ_CJMP = 3'd3,
        SEQ_WAIT = 3'd4,
        SEQ_CALL = 3'd5,
        SEQ_RET  = 3'd6,
        SEQ_RSV  = 3'd7
    } seq_op_e;

    // Width of the cond_sel field; at least one bit even for a single condition.
    function automatic int cs_width(input int n_cond);
        return (n_cond > 1) ? $clog2(n_cond) : 1;
    endfunction

    // Total microinstruction width.
    function automatic int mi_width(input int ctrl_w, input int state_w, input int n_cond);
        return ctrl_w + state_w + SEQ_OP_W + cs_width(n_cond) + 1;
    endfunction

    // Width needed to count 0..depth occupied stack entries.
    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a stack slot pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/microsequencer_useq_stack.sv
// -----------------------------------------------------------------------------
// useq_stack
// Return-address LIFO for the microsequencer.
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset (empties the stack)
//   push_i   push data_i (ignored when full)
//   pop_i    pop the top entry (ignored when empty)
//   data_i   value to push
//   top_o    current top entry (0 when empty)
//   level_o  number of occupied entries
//   full_o   stack holds DEPTH entries
//   empty_o  stack holds no entries
// -----------------------------------------------------------------------------
module useq_stack
    import microsequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [WIDTH-1:0]             top_o,
    output logic [lvl_width(DEPTH)-1:0]  level_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int LVL_W = lvl_width(DEPTH);
    localparam int PTR_W = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic [PTR_W-1:0] wr_ptr_s;
    logic [PTR_W-1:0] rd_ptr_s;
    logic             full_s;
    logic             empty_s;

    assign full_s   = (level_q == LVL_W'(DEPTH));
    assign empty_s  = (level_q == {LVL_W{1'b0}});
    // Next free slot is at index level; top sits just below it.
    assign wr_ptr_s = level_q[PTR_W-1:0];
    assign rd_ptr_s = wr_ptr_s - {{(PTR_W-1){1'b0}}, 1'b1};

    // Next occupancy from the guarded push/pop requests.
    always_comb begin
        level_d = level_q;
        if (push_i && !full_s) begin
            level_d = level_q + {{(LVL_W-1){1'b0}}, 1'b1};
        end else if (pop_i && !empty_s) begin
            level_d = level_q - {{(LVL_W-1){1'b0}}, 1'b1};
        end else begin
            level_d = level_q;
        end
    end

    // Occupancy counter and entry storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= {LVL_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            level_q <= level_d;
            if (push_i && !full_s) begin
                mem_q[wr_ptr_s] <= data_i;
            end
        end
    end

    assign top_o   = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_s];
    assign level_o = level_q;
    assign full_o  = full_s;
    assign empty_o = empty_s;

endmodule

// File: rtl/microsequencer.sv
// -----------------------------------------------------------------------------
// microsequencer
// Microprogram sequencer: holds the microinstruction register and current
// state, selects the next microaddress, and owns the call/return stack.
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous active-low reset
//   hold           freezes all state while high
//   cond           live condition inputs (cond[0] = MOC)
//   decode_addr    opcode dispatch address from the encoder
//   uword          microstore word at uaddr
//   uaddr          next microaddress to the microstore (combinational)
//   ctrl           registered datapath control word
//   current_state  address of the microinstruction in the register
//   stack_level    occupied return-stack entries
//   fault          sticky sequencing fault flag
// -----------------------------------------------------------------------------
module microsequencer
    import microsequencer_pkg::*;
#(
    parameter int                 STATE_W     = 10,
    parameter int                 CTRL_W      = 24,
    parameter int                 N_COND      = 4,
    parameter int                 STACK_DEPTH = 4,
    parameter logic [STATE_W-1:0] FAULT_ADDR  = {STATE_W{1'b1}}
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    hold,
    input  logic [N_COND-1:0]                       cond,
    input  logic [STATE_W-1:0]                      decode_addr,
    input  logic [mi_width(CTRL_W,STATE_W,N_COND)-1:0] uword,
    output logic [STATE_W-1:0]                      uaddr,
    output logic [CTRL_W-1:0]                       ctrl,
    output logic [STATE_W-1:0]                      current_state,
    output logic [lvl_width(STACK_DEPTH)-1:0]       stack_level,
    output logic                                    fault
);

    localparam int CS_W     = cs_width(N_COND);
    localparam int MI_W     = mi_width(CTRL_W, STATE_W, N_COND);
    localparam int LVL_W    = lvl_width(STACK_DEPTH);
    localparam int SEL_LSB  = 1;
    localparam int OP_LSB   = SEL_LSB + CS_W;
    localparam int NA_LSB   = OP_LSB + SEQ_OP_W;
    localparam int CTRL_LSB = NA_LSB + STATE_W;

    // Reset leaves a "JMP 0" with a zero control field in the register, so the
    // first un-held edge after release fetches word 0.
    localparam logic [MI_W-1:0] IR_RESET = MI_W'(SEQ_JMP) << OP_LSB;

    logic [MI_W-1:0]    ir_q;
    logic [MI_W-1:0]    ir_d;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               fault_q;
    logic               fault_d;

    logic [STATE_W-1:0] next_addr_s;
    seq_op_e            op_s;
    logic [CS_W-1:0]    sel_s;
    logic               inv_s;
    logic               cond_bit_s;
    logic               c_s;
    logic [STATE_W-1:0] inc_s;
    logic [STATE_W-1:0] uaddr_s;
    logic               push_s;
    logic               pop_s;
    logic               fault_set_s;

    logic [STATE_W-1:0] stk_top_s;
    logic               stk_full_s;
    logic               stk_empty_s;
    logic [LVL_W-1:0]   stk_level_s;

    assign next_addr_s = ir_q[NA_LSB +: STATE_W];
    assign op_s        = seq_op_e'(ir_q[OP_LSB +: SEQ_OP_W]);
    assign sel_s       = ir_q[SEL_LSB +: CS_W];
    assign inv_s       = ir_q[0];
    assign inc_s       = state_q + {{(STATE_W-1){1'b0}}, 1'b1};

    // Condition select; selectors beyond N_COND match no input and read 0.
    always_comb begin
        cond_bit_s = 1'b0;
        for (int i = 0; i < N_COND; i++) begin
            cond_bit_s = cond_bit_s | ((sel_s == CS_W'(i)) & cond[i]);
        end
        c_s = cond_bit_s ^ inv_s;
    end

    // Next-address mux with stack requests and fault detection.
    always_comb begin
        uaddr_s     = inc_s;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        fault_set_s = 1'b0;
        case (op_s)
            SEQ_INC:  uaddr_s = inc_s;
            SEQ_JMP:  uaddr_s = next_addr_s;
            SEQ_DEC:  uaddr_s = decode_addr;
            SEQ_CJMP: uaddr_s = c_s ? next_addr_s : inc_s;
            SEQ_WAIT: uaddr_s = c_s ? inc_s : state_q;
            SEQ_CALL: begin
                if (stk_full_s) begin
                    uaddr_s     = FAULT_ADDR;
                    fault_set_s = 1'b1;
                end else begin
                    uaddr_s = next_addr_s;
                    push_s  = 1'b1;
                end
            end
            SEQ_RET: begin
                if (stk_empty_s) begin
                    uaddr_s     = FAULT_ADDR;
                    fault_set_s = 1'b1;
                end else begin
                    uaddr_s = stk_top_s;
                    pop_s   = 1'b1;
                end
            end
            SEQ_RSV: begin
                uaddr_s     = FAULT_ADDR;
                fault_set_s = 1'b1;
            end
            default: begin
                uaddr_s     = FAULT_ADDR;
                fault_set_s = 1'b1;
            end
        endcase
    end

    // Register next-state: everything holds while hold is high.
    always_comb begin
        ir_d    = ir_q;
        state_d = state_q;
        fault_d = fault_q;
        if (hold) begin
            ir_d    = ir_q;
            state_d = state_q;
            fault_d = fault_q;
        end else begin
            ir_d    = uword;
            state_d = uaddr_s;
            fault_d = fault_q | fault_set_s;
        end
    end

    // Microinstruction register, current state and sticky fault.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q    <= IR_RESET;
            state_q <= {STATE_W{1'b0}};
            fault_q <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    useq_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (STATE_W)
    ) u_stack (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push_s & ~hold),
        .pop_i   (pop_s & ~hold),
        .data_i  (inc_s),
        .top_o   (stk_top_s),
        .level_o (stk_level_s),
        .full_o  (stk_full_s),
        .empty_o (stk_empty_s)
    );

    assign uaddr         = reset ? uaddr_s : {STATE_W{1'b0}};
    assign ctrl          = ir_q[CTRL_LSB +: CTRL_W];
    assign current_state = state_q;
    assign stack_level   = stk_level_s;
    assign fault         = fault_q;

endmodule

// File: tb/tb_microsequencer.sv
// -----------------------------------------------------------------------------
// tb_microsequencer
// Self-checking bench: a field-level microstore feeds the DUT, and a reference
// model (state integer, control word, return stack as a queue, fault bit)
// predicts uaddr before each edge and all registered outputs after it.
// Directed programs cover the documented scenarios; a randomized phase runs
// random microcode with random conditions, holds and resets.
// -----------------------------------------------------------------------------
module tb_microsequencer;

    localparam int STATE_W = 10;
    localparam int CTRL_W  = 24;
    localparam int N_COND  = 4;
    localparam int DEPTH   = 4;
    localparam int MI_W    = 40;
    localparam int NWORDS  = 1024;
    localparam int FADDR   = 1023;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                hold = 1'b0;
    logic [N_COND-1:0]   cond = 4'd0;
    logic [STATE_W-1:0]  decode_addr = 10'd0;
    logic [MI_W-1:0]     uword;
    logic [STATE_W-1:0]  uaddr;
    logic [CTRL_W-1:0]   ctrl;
    logic [STATE_W-1:0]  current_state;
    logic [2:0]          stack_level;
    logic                fault;

    // Microstore held as separate fields; packed per the documented layout.
    logic [23:0] r_ctrl [NWORDS];
    logic [9:0]  r_na   [NWORDS];
    logic [2:0]  r_op   [NWORDS];
    logic [1:0]  r_sel  [NWORDS];
    logic        r_inv  [NWORDS];

    assign uword = {r_ctrl[uaddr], r_na[uaddr], r_op[uaddr], r_sel[uaddr], r_inv[uaddr]};

    microsequencer dut (
        .clk           (clk),
        .reset         (reset),
        .hold          (hold),
        .cond          (cond),
        .decode_addr   (decode_addr),
        .uword         (uword),
        .uaddr         (uaddr),
        .ctrl          (ctrl),
        .current_state (current_state),
        .stack_level   (stack_level),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int          m_state;
    logic [23:0] m_ctrl;
    int          m_stack[$];
    bit          m_fault;
    bit          m_boot;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic put(input int a, input logic [23:0] c, input int na, input int op,
                       input int sel, input bit inv);
        r_ctrl[a] = c;
        r_na[a]   = 10'(na);
        r_op[a]   = 3'(op);
        r_sel[a]  = 2'(sel);
        r_inv[a]  = inv;
    endtask

    task automatic fill_plain();
        for (int a = 0; a < NWORDS; a++) begin
            put(a, 24'(a * 24'h010101 + 24'h000123), 0, 0, 0, 1'b0);
        end
    endtask

    task automatic fill_random();
        int op;
        for (int a = 0; a < NWORDS; a++) begin
            op = $urandom_range(0, 7);
            if (op == 7 && $urandom_range(0, 3) != 0) op = 0;
            put(a, 24'($urandom), $urandom_range(0, NWORDS - 1), op,
                $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    // Predicted next microaddress from the documented sequencing rules.
    function automatic int model_next(output bit push, output bit pop, output bit flt);
        int s, inc, res;
        bit c;
        push = 1'b0; pop = 1'b0; flt = 1'b0;
        if (m_boot) return 0;
        s   = m_state;
        inc = (s + 1) % NWORDS;
        // Every 2-bit selector names a real input when N_COND is 4.
        c   = cond[r_sel[s]] ^ r_inv[s];
        case (r_op[s])
            3'd0: res = inc;
            3'd1: res = int'(r_na[s]);
            3'd2: res = int'(decode_addr);
            3'd3: res = c ? int'(r_na[s]) : inc;
            3'd4: res = c ? inc : s;
            3'd5: begin
                if (m_stack.size() == DEPTH) begin flt = 1'b1; res = FADDR; end
                else begin push = 1'b1; res = int'(r_na[s]); end
            end
            3'd6: begin
                if (m_stack.size() == 0) begin flt = 1'b1; res = FADDR; end
                else begin pop = 1'b1; res = m_stack[$]; end
            end
            default: begin flt = 1'b1; res = FADDR; end
        endcase
        return res;
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, ".state"}, 32'(current_state), 32'(m_state));
        check_eq({tag, ".ctrl"},  32'(ctrl),          32'(m_ctrl));
        check_eq({tag, ".level"}, 32'(stack_level),   32'(m_stack.size()));
        check_eq({tag, ".fault"}, 32'(fault),         32'(m_fault));
    endtask

    // One clock: called at posedge+1, returns at the following posedge+1.
    task automatic step(input bit h, input logic [3:0] cv);
        int nxt, inc;
        bit pu, po, fl;
        hold = h;
        cond = cv;
        @(negedge clk);
        nxt = model_next(pu, po, fl);
        check_eq("uaddr", 32'(uaddr), 32'(nxt));
        @(posedge clk);
        #1;
        if (!h) begin
            inc = (m_state + 1) % NWORDS;
            if (pu) m_stack.push_back(inc);
            if (po) void'(m_stack.pop_back());
            m_state = nxt;
            m_ctrl  = r_ctrl[nxt];
            m_fault = m_fault | fl;
            m_boot  = 1'b0;
        end
        check_outputs("step");
    endtask

    // Assert reset, check the asynchronous clear, release after one edge.
    task automatic do_reset(input bit refill);
        reset = 1'b0;
        #2;
        check_eq("rst.state", 32'(current_state), 32'd0);
        check_eq("rst.ctrl",  32'(ctrl),          32'd0);
        check_eq("rst.level", 32'(stack_level),   32'd0);
        check_eq("rst.fault", 32'(fault),         32'd0);
        check_eq("rst.uaddr", 32'(uaddr),         32'd0);
        if (refill) fill_random();
        m_state = 0;
        m_ctrl  = 24'd0;
        m_stack.delete();
        m_fault = 1'b0;
        m_boot  = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("rst.held");
        reset = 1'b1;
    endtask

    initial begin
        fill_plain();
        put(0,        24'hA5A5A5, 0,        0, 0, 1'b0);
        put(1,        24'h111111, 5,        1, 0, 1'b0);
        put(5,        24'h050505, 0,        4, 0, 1'b0);
        put(6,        24'h060606, 0,        4, 0, 1'b1);
        put(7,        24'h070707, 0,        2, 0, 1'b0);
        put(10'h040,  24'h404040, 10'h100,  3, 1, 1'b0);
        put(10'h100,  24'h100100, 10'h200,  3, 1, 1'b0);
        put(10'h101,  24'h101101, 10,       1, 0, 1'b0);
        put(10,       24'h0A0A0A, 10'h200,  5, 0, 1'b0);
        put(10'h201,  24'h201201, 10'h300,  5, 0, 1'b0);
        put(10'h300,  24'h300300, 0,        6, 0, 1'b0);
        put(10'h202,  24'h202202, 0,        6, 0, 1'b0);
        put(11,       24'h0B0B0B, 10'h3FE,  1, 0, 1'b0);
        for (int a = 10'h020; a <= 10'h024; a++) put(a, 24'(a), a + 1, 5, 0, 1'b0);
        put(10'h030,  24'h303030, 0,        6, 0, 1'b0);

        #1;
        // Phase A: boot, WAIT, DEC, CJMP, nested CALL/RET, hold, wrap.
        do_reset(1'b0);
        step(1'b0, 4'd0);
        check_eq("boot.ctrl", 32'(ctrl), 32'hA5A5A5);
        check_eq("boot.state", 32'(current_state), 32'd0);
        step(1'b0, 4'd0);
        check_eq("boot.next", 32'(current_state), 32'd1);
        step(1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'd0);
            check_eq("wait.moc_low", 32'(current_state), 32'd5);
        end
        step(1'b0, 4'd1);
        check_eq("wait.moc_rise", 32'(current_state), 32'd6);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 4'd1);
            check_eq("wait_inv.moc_high", 32'(current_state), 32'd6);
        end
        decode_addr = 10'h040;
        step(1'b0, 4'd0);
        step(1'b0, 4'd0);
        check_eq("dec", 32'(current_state), 32'h040);
        step(1'b0, 4'b0010);
        check_eq("cjmp.taken", 32'(current_state), 32'h100);
        step(1'b0, 4'b0000);
        check_eq("cjmp.not_taken", 32'(current_state), 32'h101);
        step(1'b0, 4'd0);
        step(1'b0, 4'd0);
        check_eq("call1.level", 32'(stack_level), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'($urandom));
            check_eq("hold.state", 32'(current_state), 32'h200);
        end
        step(1'b0, 4'd0);
        step(1'b0, 4'd0);
        check_eq("call2.level", 32'(stack_level), 32'd2);
        step(1'b0, 4'd0);
        check_eq("ret1.state", 32'(current_state), 32'h202);
        step(1'b0, 4'd0);
        check_eq("ret2.state", 32'(current_state), 32'd11);
        check_eq("ret2.level", 32'(stack_level), 32'd0);
        step(1'b0, 4'd0);
        step(1'b0, 4'd0);
        step(1'b0, 4'd0);
        check_eq("wrap", 32'(current_state), 32'd0);

        // Phase B: reset under hold, then stack overflow.
        step(1'b0, 4'd0);
        hold = 1'b1;
        do_reset(1'b0);
        decode_addr = 10'h020;
        step(1'b0, 4'd1);
        step(1'b0, 4'd1);
        step(1'b0, 4'd1);
        step(1'b0, 4'd1);
        step(1'b0, 4'd0);
        step(1'b0, 4'd0);
        check_eq("ovf.entry", 32'(current_state), 32'h020);
        for (int i = 0; i < 5; i++) step(1'b0, 4'd0);
        check_eq("ovf.state", 32'(current_state), 32'h3FF);
        check_eq("ovf.fault", 32'(fault), 32'd1);
        check_eq("ovf.level", 32'(stack_level), 32'd4);
        step(1'b0, 4'd0);
        step(1'b0, 4'd0);
        check_eq("ovf.sticky", 32'(fault), 32'd1);

        // Phase C: return on an empty stack.
        do_reset(1'b0);
        decode_addr = 10'h030;
        step(1'b0, 4'd1);
        step(1'b0, 4'd1);
        step(1'b0, 4'd1);
        step(1'b0, 4'd1);
        step(1'b0, 4'd0);
        step(1'b0, 4'd0);
        step(1'b0, 4'd0);
        check_eq("unf.state", 32'(current_state), 32'h3FF);
        check_eq("unf.fault", 32'(fault), 32'd1);

        // Phase D: random microcode against the model.
        do_reset(1'b1);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset(1'b1);
            decode_addr = 10'($urandom_range(0, NWORDS - 1));
            step($urandom_range(0, 7) == 0, 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
